// File: rtl/zap_wb_arbiter_pkg.sv
// Shared constants and types for the Wishbone arbiter: CTI codes and FSM state encoding.
// Used by zap_wb_arbiter; timeout logic is enabled by defining ZAP_WB_ARB_TIMEOUT_EN.
package zap_wb_arbiter_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // A cycle type that closes a transfer on its acknowledge.
    function automatic logic cti_is_last(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
    endfunction

endpackage

// File: rtl/zap_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr+1 (mod NUM_MASTERS), one-hot out.
module zap_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int IW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          ptr,
    output logic [NUM_MASTERS-1:0] gnt
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;
    logic          found_s;

    // Scan candidates in rotated order; ptr+1+i never exceeds 2*NUM_MASTERS-1, so one wrap suffices.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sum_s = {1'b0, ptr} + (IW+1)'(i) + (IW+1)'(1);
            if (sum_s >= (IW+1)'(NUM_MASTERS)) begin
                sum_s = sum_s - (IW+1)'(NUM_MASTERS);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IW-1:0];
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/zap_wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS requesters onto one slave bus, burst-aware.
// Define ZAP_WB_ARB_TIMEOUT_EN to add the ack-wait timeout with forced release and err pulse.
module zap_wb_arbiter
    import zap_wb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [NUM_MASTERS-1:0]    i_m_wb_cyc,
    input  logic [NUM_MASTERS-1:0]    i_m_wb_stb,
    input  logic [NUM_MASTERS-1:0]    i_m_wb_wen,
    input  logic [4*NUM_MASTERS-1:0]  i_m_wb_sel,
    input  logic [32*NUM_MASTERS-1:0] i_m_wb_dat,
    input  logic [32*NUM_MASTERS-1:0] i_m_wb_adr,
    input  logic [3*NUM_MASTERS-1:0]  i_m_wb_cti,
    output logic [NUM_MASTERS-1:0]    o_m_wb_ack,
    output logic [NUM_MASTERS-1:0]    o_m_wb_err,
    output logic [31:0]               o_m_wb_dat,
    output logic                      o_wb_cyc,
    output logic                      o_wb_stb,
    output logic                      o_wb_wen,
    output logic [3:0]                o_wb_sel,
    output logic [31:0]               o_wb_dat,
    output logic [31:0]               o_wb_adr,
    output logic [2:0]                o_wb_cti,
    input  logic                      i_wb_ack,
    input  logic [31:0]               i_wb_dat,
    output logic [NUM_MASTERS-1:0]    o_gnt
);

    localparam int IW = $clog2(NUM_MASTERS);

    arb_state_t             state_ff, state_nxt;
    logic [NUM_MASTERS-1:0] gnt_ff, gnt_nxt, pick_s;
    logic [IW-1:0]          last_ff, last_nxt, owner_s;
    logic                   mux_cyc_s, mux_stb_s, mux_wen_s;
    logic [3:0]             mux_sel_s;
    logic [31:0]            mux_dat_s, mux_adr_s;
    logic [2:0]             mux_cti_s;
    logic                   end_s, timeout_s;

    function automatic logic [IW-1:0] onehot_idx(input logic [NUM_MASTERS-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (oh[k]) begin
                r = IW'(k);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    zap_rr_pick #(.NUM_MASTERS(NUM_MASTERS), .IW(IW)) u_pick (
        .req (i_m_wb_cyc),
        .ptr (last_ff),
        .gnt (pick_s)
    );

    // State register: FSM state, one-hot grant and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_ff <= ST_IDLE;
            gnt_ff   <= '0;
            last_ff  <= IW'(NUM_MASTERS-1);
        end else begin
            state_ff <= state_nxt;
            gnt_ff   <= gnt_nxt;
            last_ff  <= last_nxt;
        end
    end

`ifdef ZAP_WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT-1);
    logic [7:0] wait_cnt_ff;

    // Ack-wait counter: zero while idle and on every ack, counts busy cycles otherwise.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt_ff <= 8'd0;
        end else if ((state_ff == ST_IDLE) || i_wb_ack) begin
            wait_cnt_ff <= 8'd0;
        end else begin
            wait_cnt_ff <= wait_cnt_ff + 8'd1;
        end
    end

    assign timeout_s = (state_ff == ST_BUSY) && !i_wb_ack && (wait_cnt_ff == TO_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Owner mux: one-hot AND-OR select, all-zero when nothing is granted.
    always_comb begin
        owner_s   = onehot_idx(gnt_ff);
        mux_cyc_s = |(i_m_wb_cyc & gnt_ff);
        mux_stb_s = |(i_m_wb_stb & gnt_ff);
        mux_wen_s = |(i_m_wb_wen & gnt_ff);
        mux_sel_s = '0;
        mux_dat_s = '0;
        mux_adr_s = '0;
        mux_cti_s = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            mux_sel_s = mux_sel_s | ({4{gnt_ff[k]}}  & i_m_wb_sel[4*k +: 4]);
            mux_dat_s = mux_dat_s | ({32{gnt_ff[k]}} & i_m_wb_dat[32*k +: 32]);
            mux_adr_s = mux_adr_s | ({32{gnt_ff[k]}} & i_m_wb_adr[32*k +: 32]);
            mux_cti_s = mux_cti_s | ({3{gnt_ff[k]}}  & i_m_wb_cti[3*k +: 3]);
        end
    end

    // Next-state: arbitrate only from IDLE; a burst holds the bus until its last ack.
    always_comb begin
        state_nxt = state_ff;
        gnt_nxt   = gnt_ff;
        last_nxt  = last_ff;
        end_s     = !mux_cyc_s || (i_wb_ack && cti_is_last(mux_cti_s)) || timeout_s;
        case (state_ff)
            ST_IDLE: begin
                if (|i_m_wb_cyc) begin
                    state_nxt = ST_BUSY;
                    gnt_nxt   = pick_s;
                end else begin
                    gnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (end_s) begin
                    state_nxt = ST_IDLE;
                    gnt_nxt   = '0;
                    last_nxt  = owner_s;
                end else begin
                    state_nxt = ST_BUSY;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: route the owner while busy; a timeout drops cyc in the cycle it fires.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_wen   = 1'b0;
        o_wb_sel   = 4'h0;
        o_wb_dat   = 32'h0;
        o_wb_adr   = 32'h0;
        o_wb_cti   = 3'b000;
        o_m_wb_ack = '0;
        o_m_wb_err = '0;
        o_gnt      = gnt_ff;
        o_m_wb_dat = i_reset_n ? i_wb_dat : 32'h0;
        if (state_ff == ST_BUSY) begin
            o_wb_cyc   = mux_cyc_s && !timeout_s;
            o_wb_stb   = mux_stb_s;
            o_wb_wen   = mux_wen_s;
            o_wb_sel   = mux_sel_s;
            o_wb_dat   = mux_dat_s;
            o_wb_adr   = mux_adr_s;
            o_wb_cti   = mux_cti_s;
            o_m_wb_ack = gnt_ff & {NUM_MASTERS{i_wb_ack}};
            o_m_wb_err = gnt_ff & {NUM_MASTERS{timeout_s}};
        end else begin
            o_gnt      = '0;
        end
    end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter (default build, ZAP_WB_ARB_TIMEOUT_EN undefined).
module tb_zap_wb_arbiter;

    localparam int NM = 4;

    logic            i_clk = 1'b0;
    logic            i_reset_n;
    logic [NM-1:0]   i_m_wb_cyc, i_m_wb_stb, i_m_wb_wen;
    logic [4*NM-1:0] i_m_wb_sel;
    logic [32*NM-1:0] i_m_wb_dat, i_m_wb_adr;
    logic [3*NM-1:0] i_m_wb_cti;
    logic [NM-1:0]   o_m_wb_ack, o_m_wb_err, o_gnt;
    logic [31:0]     o_m_wb_dat, o_wb_dat, o_wb_adr, i_wb_dat;
    logic            o_wb_cyc, o_wb_stb, o_wb_wen, i_wb_ack;
    logic [3:0]      o_wb_sel;
    logic [2:0]      o_wb_cti;
    logic [NM-1:0]   err_seen;

    int n_checks = 0;
    int n_fail   = 0;

    zap_wb_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_m_wb_cyc(i_m_wb_cyc), .i_m_wb_stb(i_m_wb_stb), .i_m_wb_wen(i_m_wb_wen),
        .i_m_wb_sel(i_m_wb_sel), .i_m_wb_dat(i_m_wb_dat), .i_m_wb_adr(i_m_wb_adr),
        .i_m_wb_cti(i_m_wb_cti), .o_m_wb_ack(o_m_wb_ack), .o_m_wb_err(o_m_wb_err),
        .o_m_wb_dat(o_m_wb_dat), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_wen(o_wb_wen), .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat),
        .o_wb_adr(o_wb_adr), .o_wb_cti(o_wb_cti), .i_wb_ack(i_wb_ack),
        .i_wb_dat(i_wb_dat), .o_gnt(o_gnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic req(input logic [NM-1:0] v);
        i_m_wb_cyc = v;
        i_m_wb_stb = v;
    endtask

    task automatic set_cti(input int k, input logic [2:0] v);
        i_m_wb_cti[3*k +: 3] = v;
    endtask

    initial begin
        i_reset_n  = 1'b0;
        i_wb_ack   = 1'b0;
        i_wb_dat   = 32'h1234_5678;
        i_m_wb_wen = 4'b0100;
        i_m_wb_cti = '0;
        req(4'b0110);
        for (int k = 0; k < NM; k++) begin
            i_m_wb_sel[4*k +: 4]   = 4'(k + 1);
            i_m_wb_adr[32*k +: 32] = 32'h1000_0000 + 32'(k);
            i_m_wb_dat[32*k +: 32] = 32'hD000_0000 + 32'(k);
        end
        #12;
        check_eq("rst_gnt", 32'(o_gnt), 32'h0);
        check_eq("rst_cyc", 32'(o_wb_cyc), 32'h0);
        check_eq("rst_mdat", o_m_wb_dat, 32'h0);

        // Classic arbitration from reset: master 1 then master 2.
        i_reset_n = 1'b1;
        #1;
        check_eq("idle_cyc", 32'(o_wb_cyc), 32'h0);
        tick();
        check_eq("gnt_m1", 32'(o_gnt), 32'h2);
        check_eq("m1_adr", o_wb_adr, 32'h1000_0001);
        check_eq("m1_dat", o_wb_dat, 32'hD000_0001);
        check_eq("m1_sel", 32'(o_wb_sel), 32'h2);
        check_eq("m1_wen", 32'(o_wb_wen), 32'h0);
        check_eq("m1_stb", 32'(o_wb_stb), 32'h1);
        i_wb_ack = 1'b1;
        i_wb_dat = 32'hCAFE_0001;
        #1;
        check_eq("m1_ack", 32'(o_m_wb_ack), 32'h2);
        check_eq("m1_rdat", o_m_wb_dat, 32'hCAFE_0001);
        tick();
        check_eq("idle_gnt", 32'(o_gnt), 32'h0);
        check_eq("idle_ack", 32'(o_m_wb_ack), 32'h0);
        check_eq("idle_stb", 32'(o_wb_stb), 32'h0);
        i_wb_ack = 1'b0;
        tick();
        check_eq("gnt_m2", 32'(o_gnt), 32'h4);
        check_eq("m2_wen", 32'(o_wb_wen), 32'h1);
        check_eq("m2_adr", o_wb_adr, 32'h1000_0002);
        i_wb_ack = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        req(4'b0001);
        set_cti(0, 3'b010);
        tick();
        check_eq("gnt_m0", 32'(o_gnt), 32'h1);

        // Burst by master 0 while master 3 waits.
        req(4'b1001);
        for (int b = 0; b < 4; b++) begin
            set_cti(0, (b < 3) ? 3'b010 : 3'b111);
            i_wb_ack = 1'b1;
            #1;
            check_eq("burst_ack", 32'(o_m_wb_ack), 32'h1);
            tick();
            check_eq("burst_gnt", 32'(o_gnt), (b < 3) ? 32'h1 : 32'h0);
        end
        i_wb_ack = 1'b0;
        set_cti(0, 3'b000);
        req(4'b1000);
        tick();
        check_eq("gnt_m3", 32'(o_gnt), 32'h8);

        // Ack with stb low is still forwarded to the owner.
        i_m_wb_stb = 4'b0000;
        i_wb_ack   = 1'b1;
        #1;
        check_eq("nostb_ack", 32'(o_m_wb_ack), 32'h8);
        tick();
        check_eq("m3_end", 32'(o_gnt), 32'h0);
        i_wb_ack = 1'b0;
        req(4'b1000);
        tick();
        check_eq("regrant", 32'(o_gnt), 32'h8);

        // Owner drops cyc mid-burst: release without ack, pointer moves to 2.
        req(4'b0000);
        tick();
        req(4'b0100);
        set_cti(2, 3'b010);
        tick();
        check_eq("gnt_m2b", 32'(o_gnt), 32'h4);
        req(4'b0000);
        #1;
        check_eq("drop_cyc", 32'(o_wb_cyc), 32'h0);
        tick();
        check_eq("drop_idle", 32'(o_gnt), 32'h0);
        set_cti(2, 3'b000);
        req(4'b1111);
        tick();
        check_eq("rr_after_2", 32'(o_gnt), 32'h8);

        // No timeout in this build: owner holds the bus without acks.
        err_seen = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            err_seen = err_seen | o_m_wb_err;
        end
        check_eq("no_err", 32'(err_seen), 32'h0);
        check_eq("hold_gnt", 32'(o_gnt), 32'h8);
        check_eq("hold_cyc", 32'(o_wb_cyc), 32'h1);

        // Asynchronous reset mid-cycle while busy.
        @(posedge i_clk);
        #3;
        i_reset_n = 1'b0;
        #1;
        check_eq("arst_cyc", 32'(o_wb_cyc), 32'h0);
        check_eq("arst_gnt", 32'(o_gnt), 32'h0);
        tick();
        i_reset_n = 1'b1;
        tick();
        check_eq("post_rst_m0", 32'(o_gnt), 32'h1);
        i_wb_ack = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        tick();
        check_eq("post_rst_m1", 32'(o_gnt), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
